uart_rx_fifo: RTL

UART receiver for the pipelined CPU's peripheral space. It deserialises 8N1 frames from the `uart_rxd` pin and buffers the received bytes. The MEM-stage peripheral bus reads them through a simple pop interface. It sits directly upstream of the MEM stage's UART register decode and drives the receive-ready term of the peripheral interrupt (`irqout`).

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_rx_fifo.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame/oversampling constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every CLK_HZ/(BAUD*OVERSAMPLE) clocks (truncated).
// Latency: first pulse DIV cycles after reset release, then every DIV cycles.
// Backpressure: none, free-running.
module uart_baud_tick #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset_b,
  output logic tick
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with buffered bytes; UART_RX_FIFO_EN selects a DEPTH-entry FIFO, else one holding register.
// Latency: byte visible one cycle after the stop-bit sample, about 9.5 bit times after the start edge.
// Backpressure: none on the line; a byte arriving with the buffer full (and no pop) is dropped and sets overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600,
  parameter int DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       uart_rxd,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       overflow,
  output logic       frame_err,
  input  logic       clr_err,
  output logic       irq
);

  localparam int BIT_W = $clog2(DATA_BITS);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two in 2..16");
  end

  logic                 tick;
  logic [1:0]           sync_q, sync_d;
  logic                 rxd_s;
  rx_state_t            state_q, state_d;
  logic [3:0]           sc_q, sc_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 armed_q, armed_d;
  logic                 overflow_q, overflow_d;
  logic                 frame_err_q, frame_err_d;
  logic                 push, ferr_set, pop, push_ok, ovf_set;

  uart_baud_tick #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk    (clk),
    .reset_b(reset_b),
    .tick   (tick)
  );

  always_comb begin
    sync_d = {sync_q[0], uart_rxd};
    rxd_s  = sync_q[1];
  end

  // armed_q blocks a new start after a low stop bit until the line has been seen high.
  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    armed_d  = armed_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rxd_s) armed_d = 1'b1;
        if (tick && armed_q && !rxd_s) begin
          state_d = START;
          sc_d    = '0;
        end
      end
      START: if (tick) begin
        if (sc_q == 4'(MID_SAMPLE)) begin
          state_d = rxd_s ? IDLE : DATA;
          sc_d    = '0;
          bit_d   = '0;
        end else begin
          sc_d = sc_q + 4'd1;
        end
      end
      DATA: if (tick) begin
        if (sc_q == 4'(OVERSAMPLE - 1)) begin
          shreg_d = {rxd_s, shreg_q[DATA_BITS-1:1]};
          sc_d    = '0;
          if (bit_q == BIT_W'(DATA_BITS - 1)) state_d = STOP;
          else bit_d = bit_q + BIT_W'(1);
        end else begin
          sc_d = sc_q + 4'd1;
        end
      end
      STOP: if (tick) begin
        if (sc_q == 4'(OVERSAMPLE - 1)) begin
          state_d = IDLE;
          sc_d    = '0;
          if (rxd_s) begin
            push = 1'b1;
          end else begin
            ferr_set = 1'b1;
            armed_d  = 1'b0;
          end
        end else begin
          sc_d = sc_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      sc_q    <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      armed_q <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      sc_q    <= sc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      armed_q <= armed_d;
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic          empty, full;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop      = rd_en && !empty;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign push_ok  = push && (!full || pop);
  assign ovf_set  = push && full && !pop;
  assign rd_data  = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
  assign rx_valid = !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (pop) rptr_d = rptr_q + PW'(1);
    if (push_ok) begin
      mem_d[wptr_q[AW-1:0]] = shreg_q;
      wptr_d                = wptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end
`else
  logic       hold_vld_q, hold_vld_d;
  logic [7:0] hold_q, hold_d;

  assign pop      = rd_en && hold_vld_q;
  assign push_ok  = push && (!hold_vld_q || pop);
  assign ovf_set  = push && hold_vld_q && !pop;
  assign rd_data  = hold_vld_q ? hold_q : 8'h00;
  assign rx_valid = hold_vld_q;

  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    if (pop) hold_vld_d = 1'b0;
    if (push_ok) begin
      hold_vld_d = 1'b1;
      hold_d     = shreg_q;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
    end
  end
`endif

  // A new error in the same cycle as clr_err stays set.
  always_comb begin
    overflow_d  = ovf_set | (overflow_q & ~clr_err);
    frame_err_d = ferr_set | (frame_err_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;
  assign irq       = rx_valid;

endmodule
